fetch_unit: RTL

- Instruction fetch stage directly upstream of decode: holds the fetch PC, issues sequential word requests to instruction memory, buffers returned instructions with their PCs, and presents them to decode over a valid/ready handshake.
- Handles front-end redirects (branch/jump resolution) by flushing buffered instructions and discarding in-flight responses.
- Instruction handed to decode on a 64-bit bus; bits [31:0] carry the instruction, bits [63:32] are zero.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, response buffer, redirect flush.
// Optional stall counter output is enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [63:0]     inst_o,
  output logic [XLEN-1:0] pc_o
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  entry_t          ibuf [DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   out_nxt;
  logic [CW:0]     credit;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redir_pc;
  logic            req_fire;
  logic            drop;
  logic            push;
  logic            pop;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign redir_pc    = {redirect_pc[XLEN-1:2], 2'b00};

  // Requests in flight plus buffered entries may never exceed DEPTH.
  assign credit = {1'b0, outstanding} + {1'b0, count};

  assign imem_req_valid = !rst && !redirect_valid
                        && (credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign head       = ibuf[rd_ptr];
  assign inst_valid = !rst && (count != '0);
  assign inst_o     = inst_valid ? {32'b0, head.inst} : '0;
  assign pc_o       = inst_valid ? head.pc : '0;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign drop     = redirect_valid || (discard != '0);
  assign push     = imem_rsp_valid && !drop;
  assign pop      = inst_valid && inst_ready && !redirect_valid;
  assign out_nxt  = outstanding + CW'(req_fire)
                  - CW'(imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        discard  <= out_nxt;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + XLEN'(4);
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (imem_rsp_valid && (discard != '0))
          discard <= discard - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      ibuf[wr_ptr] <= '{pc: rsp_pc, inst: imem_rsp_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      assert (discard <= outstanding);
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if ((!inst_valid || (imem_req_valid && !imem_req_ready))
             && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
